// File: rtl/sized_fifo_pkg.sv
// sized_fifo_pkg: shared sizing helpers for ring-buffer FIFOs of arbitrary (non-power-of-two) depth.
package sized_fifo_pkg;

    function automatic int ptr_w(int d);
        return $clog2(d) > 1 ? $clog2(d) : 1;
    endfunction

    function automatic int cnt_w(int d);
        return $clog2(d + 1);
    endfunction

    // Wrap by explicit compare so any depth works, not just powers of two.
    function automatic int ptr_inc(int p, int d);
        return p == d - 1 ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/sized_fifo_ring_mem.sv
// sized_fifo_ring_mem: depth x width register array, one synchronous write port, one asynchronous read port.
module sized_fifo_ring_mem
    import sized_fifo_pkg::*;
#(
    parameter int depth = 20,
    parameter int width = 128
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [ptr_w(depth)-1:0]   waddr_i,
    input  logic [width-1:0]          wdata_i,
    input  logic [ptr_w(depth)-1:0]   raddr_i,
    output logic [width-1:0]          rdata_o
);
    logic [width-1:0] mem_q [depth];

    always_ff @(posedge clk_i)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sized_fifo_ring.sv
// sized_fifo_ring: circular-buffer FIFO with count, occupancy flags, clear, sticky errors and optional enqueue-at-full.
module sized_fifo_ring
  import sized_fifo_pkg::*;
#(
  parameter int depth     = 20,
  parameter int width     = 128,
  parameter int pipelined = 1,
  parameter int afMargin  = 2,
  parameter int aeMargin  = 2
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    in_enq__ENA,
  input  logic [width-1:0]        in_enq_v,
  output logic                    in_enq__RDY,
  input  logic                    out_deq__ENA,
  output logic                    out_deq__RDY,
  output logic [width-1:0]        out_first,
  output logic                    out_first__RDY,
  input  logic                    ctl_clear__ENA,
  output logic                    ctl_clear__RDY,
  output logic [cnt_w(depth)-1:0] count,
  output logic                    almostFull,
  output logic                    almostEmpty,
  output logic                    err_overflow,
  output logic                    err_underflow
);
  localparam int PW = ptr_w(depth);
  localparam int CW = cnt_w(depth);
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          enq_f, deq_f;
  assign out_deq__RDY   = cnt_q != '0;
  assign out_first__RDY = out_deq__RDY;
  assign in_enq__RDY    = (cnt_q != CW'(depth)) | ((pipelined != 0) & out_deq__ENA & out_deq__RDY);
  assign ctl_clear__RDY = 1'b1;
  assign enq_f = in_enq__ENA & in_enq__RDY & ~ctl_clear__ENA;
  assign deq_f = out_deq__ENA & out_deq__RDY & ~ctl_clear__ENA;
  assign count         = cnt_q;
  assign almostFull    = cnt_q >= CW'(depth - afMargin);
  assign almostEmpty   = cnt_q <= CW'(aeMargin);
  assign err_overflow  = ovf_q;
  assign err_underflow = udf_q;
  always_comb begin
    rd_d  = ctl_clear__ENA ? '0 : deq_f ? PW'(ptr_inc(32'(rd_q), depth)) : rd_q;
    wr_d  = ctl_clear__ENA ? '0 : enq_f ? PW'(ptr_inc(32'(wr_q), depth)) : wr_q;
    cnt_d = ctl_clear__ENA ? '0 : (enq_f && !deq_f) ? cnt_q + CW'(1) : (deq_f && !enq_f) ? cnt_q - CW'(1) : cnt_q;
    ovf_d = !ctl_clear__ENA & (ovf_q | (in_enq__ENA & ~in_enq__RDY));
    udf_d = !ctl_clear__ENA & (udf_q | (out_deq__ENA & ~out_deq__RDY));
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  sized_fifo_ring_mem #(.depth(depth), .width(width)) u_mem (
    .clk_i   (CLK),
    .we_i    (enq_f),
    .waddr_i (wr_q),
    .wdata_i (in_enq_v),
    .raddr_i (rd_q),
    .rdata_o (out_first)
  );
endmodule

// File: tb/tb_sized_fifo_ring.sv
// tb_sized_fifo_ring: two FIFO configurations on one stimulus stream checked against queue models every cycle.
module tb_sized_fifo_ring;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst_n, enq, deq, clr;
  logic [W-1:0] v;
  always #5 clk = ~clk;
  logic         enq_rdy[2], deq_rdy[2], first_rdy[2], clr_rdy[2], af[2], ae[2], ovf[2], udf[2];
  logic [W-1:0] first[2];
  logic [4:0]   cnt0;
  logic [2:0]   cnt1;
  sized_fifo_ring #(.depth(20), .width(W), .pipelined(1), .afMargin(2), .aeMargin(2)) dut0 (
    .CLK(clk), .nRST(rst_n),
    .in_enq__ENA(enq), .in_enq_v(v), .in_enq__RDY(enq_rdy[0]),
    .out_deq__ENA(deq), .out_deq__RDY(deq_rdy[0]),
    .out_first(first[0]), .out_first__RDY(first_rdy[0]),
    .ctl_clear__ENA(clr), .ctl_clear__RDY(clr_rdy[0]),
    .count(cnt0), .almostFull(af[0]), .almostEmpty(ae[0]),
    .err_overflow(ovf[0]), .err_underflow(udf[0])
  );
  sized_fifo_ring #(.depth(5), .width(W), .pipelined(0), .afMargin(1), .aeMargin(1)) dut1 (
    .CLK(clk), .nRST(rst_n),
    .in_enq__ENA(enq), .in_enq_v(v), .in_enq__RDY(enq_rdy[1]),
    .out_deq__ENA(deq), .out_deq__RDY(deq_rdy[1]),
    .out_first(first[1]), .out_first__RDY(first_rdy[1]),
    .ctl_clear__ENA(clr), .ctl_clear__RDY(clr_rdy[1]),
    .count(cnt1), .almostFull(af[1]), .almostEmpty(ae[1]),
    .err_overflow(ovf[1]), .err_underflow(udf[1])
  );
  logic [W-1:0] mq[2][$];
  int dep[2] = '{20, 5};
  int pip[2] = '{1, 0};
  int afm[2] = '{2, 1};
  int aem[2] = '{2, 1};
  bit movf[2], mudf[2];
  int checks = 0, failures = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic verify(int k);
    int n = mq[k].size();
    string s = k ? "1" : "0";
    check({"count", s}, k ? 64'(cnt1) : 64'(cnt0), 64'(n));
    check({"deq_rdy", s}, 64'(deq_rdy[k]), 64'(n != 0));
    check({"first_rdy", s}, 64'(first_rdy[k]), 64'(n != 0));
    check({"enq_rdy", s}, 64'(enq_rdy[k]), 64'((n != dep[k]) || (pip[k] != 0 && deq && n != 0)));
    check({"almost_full", s}, 64'(af[k]), 64'(n >= dep[k] - afm[k]));
    check({"almost_empty", s}, 64'(ae[k]), 64'(n <= aem[k]));
    check({"overflow", s}, 64'(ovf[k]), 64'(movf[k]));
    check({"underflow", s}, 64'(udf[k]), 64'(mudf[k]));
    check({"clear_rdy", s}, 64'(clr_rdy[k]), 64'(1));
    if (n != 0) check({"first", s}, 64'(first[k]), 64'(mq[k][0]));
  endtask
  task automatic step(bit e, bit d, bit c, bit r, logic [W-1:0] val);
    enq = e; deq = d; clr = c; rst_n = !r; v = val;
    for (int k = 0; k < 2; k++) begin
      int n = mq[k].size();
      bit er = (n != dep[k]) || (pip[k] != 0 && d && n != 0);
      if (r || c) begin
        mq[k].delete();
        movf[k] = 0;
        mudf[k] = 0;
      end else begin
        if (e && !er) movf[k] = 1;
        if (d && n == 0) mudf[k] = 1;
        if (d && n != 0) void'(mq[k].pop_front());
        if (e && er) mq[k].push_back(val);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) verify(k);
  endtask
  initial begin
    int pe, pd;
    step(0, 0, 0, 1, '0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, W'(i));
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, '0);
    step(0, 0, 1, 0, '0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, W'(100 + i));
    step(1, 1, 0, 0, 16'h00AB);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, '0);
    step(0, 0, 1, 0, '0);
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 1, 0, '0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, W'(200 + i));
    step(1, 1, 1, 0, 16'h0077);
    step(1, 0, 0, 0, 16'h0005);
    step(0, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, W'(300 + i));
    step(0, 0, 0, 1, '0);
    step(1, 0, 0, 0, 16'h0001);
    step(1, 0, 0, 0, 16'h0002);
    step(0, 1, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, W'(400 + i));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);
    step(1, 0, 0, 0, 16'd500);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, W'(501 + i));
    step(0, 1, 0, 0, '0);
    pe = 50; pd = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        pe = $urandom_range(20, 85);
        pd = $urandom_range(20, 85);
      end
      step($urandom_range(0, 99) < pe, $urandom_range(0, 99) < pd,
           $urandom_range(0, 99) < 2, $urandom_range(0, 199) == 0, W'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
